fetch_unit: RTL

//  Instruction-fetch stage of the 8-bit Harvard core. Owns the program counter and drives the

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_unit_if.sv | 43 ++++
 rtl/fetch_unit_ifid_reg.sv | 46 ++++
 rtl/fetch_unit.sv | 135 +++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
//  Shared CPU definitions for the 8-bit Harvard core: address and instruction
//  widths, the bubble/halt word, the reset PC and the fetch FSM encoding.
//  The decode stage and the instruction ROM import the same package.
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0]  RESET_PC  = 6'd0;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// ----------------------------------------------------------------------------
// fetch_unit_if
//  Bus between the fetch stage, the combinational instruction ROM and the
//  decoder.
//   pc_addr        fetch -> ROM     current program counter
//   instr_in       ROM -> fetch     word at pc_addr, same cycle
//   ifid_instr     fetch -> decode  registered instruction
//   ifid_pc        fetch -> decode  address of ifid_instr
//   ifid_pc_plus1  fetch -> decode  ifid_pc + 1 (wraps)
//   ifid_valid     fetch -> decode  IF/ID holds a real instruction
//  master: fetch side.  slave: ROM/decode side.
// ----------------------------------------------------------------------------
interface fetch_unit_if
    import fetch_unit_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int IW = INSTR_W
);
    logic [AW-1:0] pc_addr;
    logic [IW-1:0] instr_in;
    logic [IW-1:0] ifid_instr;
    logic [AW-1:0] ifid_pc;
    logic [AW-1:0] ifid_pc_plus1;
    logic          ifid_valid;

    modport master (
        output pc_addr,
        input  instr_in,
        output ifid_instr,
        output ifid_pc,
        output ifid_pc_plus1,
        output ifid_valid
    );

    modport slave (
        input  pc_addr,
        output instr_in,
        input  ifid_instr,
        input  ifid_pc,
        input  ifid_pc_plus1,
        input  ifid_valid
    );
endinterface

// File: rtl/fetch_unit_ifid_reg.sv
// ----------------------------------------------------------------------------
// ifid_reg
//  IF/ID pipeline register. load captures the fetched word and its address;
//  bubble replaces the instruction with NOP and clears valid while keeping the
//  address fields; neither asserted holds everything.
//  Ports: clk, reset (sync, active high), load, bubble, d_instr, d_pc,
//         d_pc_plus1 in; q_instr, q_pc, q_pc_plus1, q_valid out.
// ----------------------------------------------------------------------------
module ifid_reg
    import fetch_unit_pkg::*;
#(
    parameter int                  AW    = ADDR_W,
    parameter int                  IW    = INSTR_W,
    parameter logic [INSTR_W-1:0]  NOP_W = NOP_INSTR
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          bubble,
    input  logic [IW-1:0] d_instr,
    input  logic [AW-1:0] d_pc,
    input  logic [AW-1:0] d_pc_plus1,
    output logic [IW-1:0] q_instr,
    output logic [AW-1:0] q_pc,
    output logic [AW-1:0] q_pc_plus1,
    output logic          q_valid
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_instr    <= IW'(NOP_W);
            q_pc       <= '0;
            q_pc_plus1 <= '0;
            q_valid    <= 1'b0;
        end else if (bubble) begin
            q_instr    <= IW'(NOP_W);
            q_valid    <= 1'b0;
        end else if (load) begin
            q_instr    <= d_instr;
            q_pc       <= d_pc;
            q_pc_plus1 <= d_pc_plus1;
            q_valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//  Instruction-fetch stage. Owns the PC, drives the combinational ROM address
//  and captures the returned word into IF/ID one clock later. Handles stall,
//  flush, branch redirect and a saturating count of valid fetches.
//  Ports: clk, reset (sync, active high), stall, flush, branch_taken,
//         branch_target in; bus (fetch_unit_if.master: pc_addr, instr_in,
//         ifid_*); fetch_count, halted out.
//  Optional: FETCH_HALT_EN -- fetching NOP_INSTR halts fetch until a branch.
//
//  state | meaning
//  RUN   | fetching, PC advances each unstalled cycle
//  HALT  | NOP fetched, PC and bubble held until branch_taken
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                  AW       = ADDR_W,
    parameter int                  IW       = INSTR_W,
    parameter logic [ADDR_W-1:0]   PC_RST   = RESET_PC,
    parameter logic [INSTR_W-1:0]  NOP_W    = NOP_INSTR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [AW-1:0]   branch_target,
    fetch_unit_if.master    bus,
    output logic [15:0]     fetch_count,
    output logic            halted
);

    localparam logic [AW-1:0] PC_ONE = AW'(1);

    fetch_state_t  state;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_next_seq;
    logic          halt_hit;
    logic          ifid_load;
    logic          ifid_bubble;

    logic [IW-1:0] q_instr;
    logic [AW-1:0] q_pc;
    logic [AW-1:0] q_pc_plus1;
    logic          q_valid;

    assign pc_next_seq = pc + PC_ONE;
    assign bus.pc_addr = pc;

`ifdef FETCH_HALT_EN
    assign halt_hit = (bus.instr_in == IW'(NOP_W));
`else
    assign halt_hit = 1'b0;
`endif

    // IF/ID control mirrors the PC priority: branch > stall > flush > normal.
    // A halting fetch is turned into a bubble rather than loaded.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (state == RUN) begin
            if (branch_taken) begin
                ifid_bubble = 1'b1;
            end else if (stall) begin
                ifid_bubble = 1'b0;
            end else if (flush || halt_hit) begin
                ifid_bubble = 1'b1;
            end else begin
                ifid_load   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= PC_RST[AW-1:0];
            fetch_count <= 16'h0;
            halted      <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (branch_taken) begin
                        pc <= branch_target;
                    end else if (stall) begin
                        pc <= pc;
                    end else if (flush) begin
                        pc <= pc_next_seq;
                    end else if (halt_hit) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        pc <= pc_next_seq;
                        if (fetch_count != 16'hFFFF) begin
                            fetch_count <= fetch_count + 16'h1;
                        end
                    end
                end
                HALT: begin
                    if (branch_taken) begin
                        state  <= RUN;
                        pc     <= branch_target;
                        halted <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    ifid_reg #(
        .AW    (AW),
        .IW    (IW),
        .NOP_W (NOP_W)
    ) u_ifid_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (ifid_load),
        .bubble     (ifid_bubble),
        .d_instr    (bus.instr_in),
        .d_pc       (pc),
        .d_pc_plus1 (pc_next_seq),
        .q_instr    (q_instr),
        .q_pc       (q_pc),
        .q_pc_plus1 (q_pc_plus1),
        .q_valid    (q_valid)
    );

    assign bus.ifid_instr    = q_instr;
    assign bus.ifid_pc       = q_pc;
    assign bus.ifid_pc_plus1 = q_pc_plus1;
    assign bus.ifid_valid    = q_valid;

endmodule
